// File: rtl/attack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : attack_sequencer
// Description : Per-player attack timing FSM (startup/active/recovery) with
//               one-deep press buffer, hitstun cancel and swing/hit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module attack_sequencer #(
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 3,
  parameter int RECOVERY_FRAMES = 8,
  parameter int BUFFER_FRAMES   = 3,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCEN,
  input  logic             atk_btn,
  input  logic             hitstun_active,
  input  logic             opp_hit_event,
  output logic             attack_active,
  output logic             attack_busy,
  output logic [1:0]       attack_state,
  output logic             attack_start,
  output logic [CNT_W-1:0] swing_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int MAX_SA     = (STARTUP_FRAMES > ACTIVE_FRAMES) ? STARTUP_FRAMES : ACTIVE_FRAMES;
  localparam int MAX_FRAMES = (MAX_SA > RECOVERY_FRAMES) ? MAX_SA : RECOVERY_FRAMES;
  localparam int FRAME_W    = $clog2(MAX_FRAMES + 1);
  localparam int BUF_W      = (BUFFER_FRAMES > 0) ? $clog2(BUFFER_FRAMES + 1) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STARTUP  = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam logic [1:0] RECOVERY = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [BUF_W-1:0]   buf_cnt;
  logic               btn_q;
  logic               connected;

  logic press;
  logic frame_done;
  logic buf_pending;
  logic start_swing;
  logic score;

  assign press       = atk_btn & ~btn_q;
  assign frame_done  = (frame_cnt == '0);
  // A press on the final recovery tick counts as buffered for the chain decision.
  assign buf_pending = (buf_cnt != '0) | (press & (BUFFER_FRAMES != 0));
  assign start_swing = SCEN & ~hitstun_active &
                       (((state == IDLE) & press) |
                        ((state == RECOVERY) & frame_done & buf_pending));
  assign score       = (state == ACTIVE) & opp_hit_event & ~connected;

  function automatic logic [FRAME_W-1:0] frame_load(input logic [1:0] s);
    case (s)
      STARTUP:  frame_load = FRAME_W'(STARTUP_FRAMES - 1);
      ACTIVE:   frame_load = FRAME_W'(ACTIVE_FRAMES - 1);
      RECOVERY: frame_load = FRAME_W'(RECOVERY_FRAMES - 1);
      default:  frame_load = '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; hitstun overrides every other transition
  always_comb begin
    state_nxt = state;
    if (SCEN) begin
      if (hitstun_active) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:     if (press)      state_nxt = STARTUP;
          STARTUP:  if (frame_done) state_nxt = ACTIVE;
          ACTIVE:   if (frame_done) state_nxt = RECOVERY;
          RECOVERY: if (frame_done) state_nxt = buf_pending ? STARTUP : IDLE;
          default:                  state_nxt = IDLE;
        endcase
      end
    end
  end

  // Frame counter, buffer, hit gating and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt    <= '0;
      buf_cnt      <= '0;
      btn_q        <= 1'b0;
      connected    <= 1'b0;
      attack_start <= 1'b0;
      swing_count  <= '0;
      hit_count    <= '0;
    end else if (SCEN) begin
      btn_q        <= atk_btn;
      attack_start <= start_swing;
      if (hitstun_active) begin
        frame_cnt <= '0;
        buf_cnt   <= '0;
        connected <= 1'b0;
      end else begin
        if (state_nxt != state) begin
          frame_cnt <= frame_load(state_nxt);
        end else if (!frame_done) begin
          frame_cnt <= frame_cnt - FRAME_W'(1);
        end

        if (start_swing) begin
          buf_cnt <= '0;
        end else if (press && (state != IDLE) && (BUFFER_FRAMES != 0)) begin
          buf_cnt <= BUF_W'(BUFFER_FRAMES);
        end else if (buf_cnt != '0) begin
          buf_cnt <= buf_cnt - BUF_W'(1);
        end

        if (start_swing) begin
          connected <= 1'b0;
        end else if (score) begin
          connected <= 1'b1;
        end

        if (start_swing && (swing_count != '1)) begin
          swing_count <= swing_count + CNT_W'(1);
        end
        if (score && (hit_count != '1)) begin
          hit_count <= hit_count + CNT_W'(1);
        end
      end
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    attack_state  = state;
    attack_busy   = (state != IDLE);
    attack_active = (state == ACTIVE) & ~connected;
  end

endmodule
`default_nettype wire

// File: tb/tb_attack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_attack_sequencer
// Description : Directed + randomized check of attack_sequencer against a
//               swing-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attack_sequencer;

  localparam int S     = 4;
  localparam int A     = 3;
  localparam int R     = 8;
  localparam int B     = 3;
  localparam int CW    = 8;
  localparam int SWING = S + A + R;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          SCEN = 1'b0;
  logic          atk_btn = 1'b0;
  logic          hitstun_active = 1'b0;
  logic          opp_hit_event = 1'b0;
  logic          attack_active;
  logic          attack_busy;
  logic [1:0]    attack_state;
  logic          attack_start;
  logic [CW-1:0] swing_count;
  logic [CW-1:0] hit_count;

  attack_sequencer #(
    .STARTUP_FRAMES (S),
    .ACTIVE_FRAMES  (A),
    .RECOVERY_FRAMES(R),
    .BUFFER_FRAMES  (B),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .SCEN          (SCEN),
    .atk_btn       (atk_btn),
    .hitstun_active(hitstun_active),
    .opp_hit_event (opp_hit_event),
    .attack_active (attack_active),
    .attack_busy   (attack_busy),
    .attack_state  (attack_state),
    .attack_start  (attack_start),
    .swing_count   (swing_count),
    .hit_count     (hit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a swing is a timeline of SWING ticks; phase derives from elapsed ticks.
  bit m_in, m_conn, m_prev, m_start;
  int m_t, m_buf, m_swings, m_hits;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_phase();
    if (!m_in)            return 0;
    else if (m_t < S)     return 1;
    else if (m_t < S + A) return 2;
    else                  return 3;
  endfunction

  task automatic model_reset();
    m_in = 0; m_conn = 0; m_prev = 0; m_start = 0;
    m_t = 0; m_buf = 0; m_swings = 0; m_hits = 0;
  endtask

  task automatic model_begin_swing();
    m_in = 1; m_t = 0; m_conn = 0; m_start = 1; m_buf = 0;
    if (m_swings < SAT) m_swings++;
  endtask

  task automatic model_step();
    bit press, pending;
    press   = atk_btn && !m_prev;
    m_prev  = atk_btn;
    m_start = 0;
    if (hitstun_active) begin
      m_in = 0; m_buf = 0; m_conn = 0;
    end else if (m_in) begin
      if (m_phase() == 2 && opp_hit_event && !m_conn) begin
        m_conn = 1;
        if (m_hits < SAT) m_hits++;
      end
      pending = (m_buf > 0) || (press && B > 0);
      if (press && B > 0) m_buf = B;
      else if (m_buf > 0) m_buf--;
      m_t++;
      if (m_t == SWING) begin
        if (pending) model_begin_swing();
        else         m_in = 0;
      end
    end else begin
      if (m_buf > 0) m_buf--;
      if (press) model_begin_swing();
    end
  endtask

  task automatic check_outputs();
    check("state",  int'(attack_state),  m_phase());
    check("active", int'(attack_active), int'(m_phase() == 2 && !m_conn));
    check("busy",   int'(attack_busy),   int'(m_in));
    check("start",  int'(attack_start),  int'(m_start));
    check("swings", int'(swing_count),   m_swings);
    check("hits",   int'(hit_count),     m_hits);
  endtask

  task automatic step(input bit scen, input bit btn, input bit hs, input bit hit);
    SCEN = scen; atk_btn = btn; hitstun_active = hs; opp_hit_event = hit;
    @(posedge clk);
    if (scen) model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Single swing from a 40-tick hold
    for (int k = 0; k < 40; k++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    // Connect on first ACTIVE tick and again next tick
    for (int k = 0; k < 20; k++) step(1, k == 0, 0, (k == 5) || (k == 6));

    // Late buffered press chains; early buffered press expires
    for (int k = 0; k < 36; k++) step(1, (k == 0) || (k == 13), 0, 0);
    for (int k = 0; k < 20; k++) step(1, (k == 0) || (k == 9), 0, 0);
    for (int k = 0; k < 36; k++) step(1, (k == 0) || (k == 15), 0, 0);

    // Hitstun cancel in ACTIVE; press raised during hitstun and held
    for (int k = 0; k < 25; k++) step(1, (k == 0) || (k >= 6 && k <= 12), (k >= 5) && (k <= 7), 0);

    // Frame-enable freeze mid-STARTUP
    for (int k = 0; k < 30; k++) step(k < 2 || k > 11, k == 0, 0, k >= 2 && k <= 11);

    // Asynchronous reset mid-ACTIVE
    for (int k = 0; k < 6; k++) step(1, k == 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_state",  int'(attack_state),  0);
    check("rst_active", int'(attack_active), 0);
    check("rst_busy",   int'(attack_busy),   0);
    check("rst_swings", int'(swing_count),   0);
    model_reset();
    SCEN = 1'b1; atk_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 4) == 0);
    end

    // Drive both counters into saturation
    for (int i = 0; i < 270; i++) begin
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      for (int k = 0; k < SWING + 1; k++) step(1, 0, 0, k == 5);
    end
    check("sat_swings", int'(swing_count), SAT);
    check("sat_hits",   int'(hit_count),   SAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
